// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone 1:N multiplexer with watchdog.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DERR   = 2'd2,
        TOUT   = 2'd3
    } wb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Cycle types after which the slave stays selected on an ack.
    function automatic logic cti_is_burst(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: lowest-indexed matching slave wins.
module wb_addr_decode #(
    parameter int NUM_SLAVES = 8,
    parameter int AW         = 32,
    parameter int SW         = 3
) (
    input  logic [AW-1:0]            adr_i,
    input  logic [NUM_SLAVES*AW-1:0] match_addr_i,
    input  logic [NUM_SLAVES*AW-1:0] match_mask_i,
    output logic                     hit_o,
    output logic [SW-1:0]            idx_o
);

    // Scan from the top down so the lowest matching index overwrites the rest.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr_i & match_mask_i[i*AW +: AW]) == match_addr_i[i*AW +: AW]) begin
                hit_o = 1'b1;
                idx_o = SW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_wdt.sv
// Wishbone B4 1-master-to-N-slave multiplexer with registered slave select,
// decode-error response and an optional per-transfer watchdog.
// Define WB_MUX_WDT_TIMEOUT_EN to build the watchdog (counter, TOUT state,
// timeout_o); without it ACTIVE waits indefinitely and timeout_o is 0.
module wb_mux_wdt
    import wb_mux_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 8,
    parameter int                       AW             = 32,
    parameter int                       DW             = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR     = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK     = '0,
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master side
    input  logic [AW-1:0]               wbm_adr_i,
    input  logic [DW-1:0]               wbm_dat_i,
    input  logic [DW/8-1:0]             wbm_sel_i,
    input  logic                        wbm_we_i,
    input  logic                        wbm_cyc_i,
    input  logic                        wbm_stb_i,
    input  logic [2:0]                  wbm_cti_i,
    input  logic [1:0]                  wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic                        wbm_ack_o,
    output logic                        wbm_err_o,
    output logic                        wbm_rty_o,
    // slave side
    output logic [NUM_SLAVES*AW-1:0]    wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0]    wbs_dat_o,
    output logic [NUM_SLAVES*DW/8-1:0]  wbs_sel_o,
    output logic [NUM_SLAVES-1:0]       wbs_we_o,
    output logic [NUM_SLAVES*3-1:0]     wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]     wbs_bte_o,
    output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]       wbs_stb_o,
    input  logic [NUM_SLAVES*DW-1:0]    wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]       wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]       wbs_err_i,
    input  logic [NUM_SLAVES-1:0]       wbs_rty_i,
    // diagnostics
    output logic                        decode_err_o,
    output logic                        timeout_o,
    output logic [AW-1:0]               err_adr_o
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    wb_state_e          state_q, state_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [AW-1:0]      err_adr_q, err_adr_d;

    logic               dec_hit;
    logic [SW-1:0]      dec_idx;
    logic               active;
    logic               slv_ack, slv_err, slv_rty, slv_resp;
    logic [NUM_SLAVES-1:0] slv_onehot;

`ifdef WB_MUX_WDT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               expire;
`endif

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .SW         (SW)
    ) u_decode (
        .adr_i        (wbm_adr_i),
        .match_addr_i (MATCH_ADDR),
        .match_mask_i (MATCH_MASK),
        .hit_o        (dec_hit),
        .idx_o        (dec_idx)
    );

    assign active   = (state_q == ACTIVE);
    assign slv_ack  = wbs_ack_i[sel_q];
    assign slv_err  = wbs_err_i[sel_q];
    assign slv_rty  = wbs_rty_i[sel_q];
    assign slv_resp = slv_ack | slv_err | slv_rty;

`ifdef WB_MUX_WDT_TIMEOUT_EN
    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state: decode in IDLE, track termination/abort/expiry in ACTIVE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_adr_d = err_adr_q;
`ifdef WB_MUX_WDT_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (dec_hit) begin
                        state_d = ACTIVE;
                        sel_d   = dec_idx;
`ifdef WB_MUX_WDT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d   = DERR;
                        err_adr_d = wbm_adr_i;
                    end
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    // master abort beats a simultaneous expiry
                    state_d = IDLE;
                end else if (slv_resp) begin
`ifdef WB_MUX_WDT_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (!(slv_ack && !slv_err && !slv_rty && cti_is_burst(wbm_cti_i))) begin
                        state_d = IDLE;
                    end
                end else begin
`ifdef WB_MUX_WDT_TIMEOUT_EN
                    if (expire) begin
                        state_d   = TOUT;
                        err_adr_d = wbm_adr_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
`ifdef WB_MUX_WDT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
        endcase
    end

    // State, selected slave and error address registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_adr_q <= err_adr_d;
        end
    end

`ifdef WB_MUX_WDT_TIMEOUT_EN
    // Watchdog counter for the current transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign timeout_o = (state_q == TOUT);
`else
    assign timeout_o = 1'b0;
`endif

    // Slave request fields: strobes are one-hot, everything else broadcast.
    assign slv_onehot = NUM_SLAVES'(1) << sel_q;
    assign wbs_cyc_o  = (active && wbm_cyc_i) ? slv_onehot : '0;
    assign wbs_stb_o  = (active && wbm_cyc_i && wbm_stb_i) ? slv_onehot : '0;
    assign wbs_adr_o  = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o  = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o  = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o   = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o  = {NUM_SLAVES{wbm_cti_i}};
    assign wbs_bte_o  = {NUM_SLAVES{wbm_bte_i}};

    // Master responses: only the selected slave, only while ACTIVE.
    assign wbm_ack_o    = active & slv_ack;
    assign wbm_rty_o    = active & slv_rty;
    assign wbm_dat_o    = active ? wbs_dat_i[int'(sel_q)*DW +: DW] : '0;
    assign wbm_err_o    = (active & slv_err) | (state_q == DERR) | (state_q == TOUT);
    assign decode_err_o = (state_q == DERR);
    assign err_adr_o    = err_adr_q;

endmodule

// File: tb/tb_wb_mux_wdt.sv
// Scoreboard bench for wb_mux_wdt: 3 slaves at 0x0000/0x1000/0x2000, 4 KiB windows.
module tb_wb_mux_wdt;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]      wbm_adr_i = '0;
    logic [DW-1:0]      wbm_dat_i = '0;
    logic [DW/8-1:0]    wbm_sel_i = '1;
    logic               wbm_we_i  = 1'b0;
    logic               wbm_cyc_i = 1'b0;
    logic               wbm_stb_i = 1'b0;
    logic [2:0]         wbm_cti_i = 3'b000;
    logic [1:0]         wbm_bte_i = 2'b00;
    logic [DW-1:0]      wbm_dat_o;
    logic               wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [NS*AW-1:0]   wbs_adr_o;
    logic [NS*DW-1:0]   wbs_dat_o;
    logic [NS*DW/8-1:0] wbs_sel_o;
    logic [NS-1:0]      wbs_we_o;
    logic [NS*3-1:0]    wbs_cti_o;
    logic [NS*2-1:0]    wbs_bte_o;
    logic [NS-1:0]      wbs_cyc_o, wbs_stb_o;
    logic [NS*DW-1:0]   wbs_dat_i = '0;
    logic [NS-1:0]      wbs_ack_i = '0;
    logic [NS-1:0]      wbs_err_i = '0;
    logic [NS-1:0]      wbs_rty_i = '0;
    logic               decode_err_o, timeout_o;
    logic [AW-1:0]      err_adr_o;

    wb_mux_wdt #(
        .NUM_SLAVES     (NS),
        .AW             (AW),
        .DW             (DW),
        .MATCH_ADDR     ({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .MATCH_MASK     ({3{32'hFFFF_F000}}),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbm_adr_i    (wbm_adr_i),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_sel_i    (wbm_sel_i),
        .wbm_we_i     (wbm_we_i),
        .wbm_cyc_i    (wbm_cyc_i),
        .wbm_stb_i    (wbm_stb_i),
        .wbm_cti_i    (wbm_cti_i),
        .wbm_bte_i    (wbm_bte_i),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_ack_o    (wbm_ack_o),
        .wbm_err_o    (wbm_err_o),
        .wbm_rty_o    (wbm_rty_o),
        .wbs_adr_o    (wbs_adr_o),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_sel_o    (wbs_sel_o),
        .wbs_we_o     (wbs_we_o),
        .wbs_cti_o    (wbs_cti_o),
        .wbs_bte_o    (wbs_bte_o),
        .wbs_cyc_o    (wbs_cyc_o),
        .wbs_stb_o    (wbs_stb_o),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_i    (wbs_ack_i),
        .wbs_err_i    (wbs_err_i),
        .wbs_rty_i    (wbs_rty_i),
        .decode_err_o (decode_err_o),
        .timeout_o    (timeout_o),
        .err_adr_o    (err_adr_o)
    );

    // response encoding {rty, err, ack}
    localparam logic [2:0] R_ACK = 3'b001;
    localparam logic [2:0] R_ERR = 3'b010;

    typedef struct packed {
        logic [2:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [AW-1:0] last_err_adr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] resp, input logic [DW-1:0] data);
        exp_t e;
        e.resp = resp;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic m_req(input logic [AW-1:0] adr, input logic [2:0] cti);
        wbm_adr_i = adr;
        wbm_cti_i = cti;
        wbm_we_i  = 1'b0;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic m_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_cti_i = 3'b000;
        wbm_adr_i = '0;
    endtask

    task automatic s_clear();
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_rty_i = '0;
        wbs_dat_i = '0;
    endtask

    task automatic s_ack(input int idx, input logic [DW-1:0] data);
        wbs_ack_i[idx]         = 1'b1;
        wbs_dat_i[idx*DW +: DW] = data;
    endtask

    // Scoreboard: every master response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_resp", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'(e.resp));
                check_eq("sb_data", 64'(wbm_dat_o), 64'(e.data));
            end
        end
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL time_bound: simulation did not finish, want completion");
        $fatal(1, "time bound");
    end

    initial begin
        // ---------------- reset state ----------------
        s_clear();
        m_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cyc", 64'(wbs_cyc_o), 64'(0));
        check_eq("rst_stb", 64'(wbs_stb_o), 64'(0));
        check_eq("rst_resp", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'(0));
        check_eq("rst_pulses", 64'({decode_err_o, timeout_o}), 64'(0));
        check_eq("rst_err_adr", 64'(err_adr_o), 64'(0));
        check_eq("rst_dat", 64'(wbm_dat_o), 64'(0));
        nxt();
        rst = 1'b0;
        nxt();

        // ---------------- classic read of 0x1004 ----------------
        m_req(32'h1004, 3'b000);
        push_exp(R_ACK, 32'hCAFE_F00D);
        @(negedge clk);
        check_eq("cl_stb_n", 64'(wbs_stb_o), 64'(0));
        nxt();
        s_ack(0, 32'hDEAD_0000);              // unselected slave must be ignored
        @(negedge clk);
        check_eq("cl_stb_n1", 64'(wbs_stb_o), 64'(3'b010));
        check_eq("cl_cyc_n1", 64'(wbs_cyc_o), 64'(3'b010));
        check_eq("cl_ack_unsel", 64'(wbm_ack_o), 64'(0));
        check_eq("cl_dat_unsel", 64'(wbm_dat_o), 64'(0));
        nxt();
        s_clear();
        s_ack(1, 32'hCAFE_F00D);
        @(negedge clk);
        check_eq("cl_ack_n2", 64'(wbm_ack_o), 64'(1));
        nxt();
        s_clear();
        m_idle();
        @(negedge clk);
        check_eq("cl_stb_done", 64'(wbs_stb_o), 64'(0));
        nxt();

        // ---------------- decode miss at 0x5000 ----------------
        m_req(32'h5000, 3'b000);
        push_exp(R_ERR, 32'h0);
        @(negedge clk);
        check_eq("de_pulse_n", 64'(decode_err_o), 64'(0));
        nxt();
        @(negedge clk);
        check_eq("de_pulse_n1", 64'(decode_err_o), 64'(1));
        check_eq("de_stb_n1", 64'(wbs_stb_o), 64'(0));
        check_eq("de_err_adr", 64'(err_adr_o), 64'(32'h5000));
        last_err_adr = 32'h5000;
        nxt();
        m_idle();
        @(negedge clk);
        check_eq("de_pulse_n2", 64'({wbm_err_o, decode_err_o}), 64'(0));
        nxt();

        // ---------------- dead slave 2 at 0x2000 ----------------
        m_req(32'h2000, 3'b000);
`ifdef WB_MUX_WDT_TIMEOUT_EN
        push_exp(R_ERR, 32'h0);
        nxt();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            check_eq($sformatf("to_stb_%0d", k), 64'(wbs_stb_o), 64'(3'b100));
            check_eq($sformatf("to_quiet_%0d", k), 64'({wbm_err_o, timeout_o}), 64'(0));
            nxt();
        end
        @(negedge clk);
        check_eq("to_pulse", 64'({wbm_err_o, timeout_o}), 64'(2'b11));
        check_eq("to_stb_low", 64'(wbs_stb_o), 64'(0));
        check_eq("to_err_adr", 64'(err_adr_o), 64'(32'h2000));
        last_err_adr = 32'h2000;
        nxt();
        @(negedge clk);
        check_eq("to_idle_stb", 64'(wbs_stb_o), 64'(0));
        check_eq("to_idle_quiet", 64'({wbm_err_o, timeout_o}), 64'(0));
        nxt();
        @(negedge clk);
        check_eq("to_redecode", 64'(wbs_stb_o), 64'(3'b100));
        m_idle();
        #1;
        check_eq("to_abort_stb", 64'(wbs_stb_o), 64'(0));
        nxt();
`else
        nxt();
        for (int k = 1; k <= 3 * TO; k++) begin
            @(negedge clk);
            check_eq($sformatf("nw_stb_%0d", k), 64'(wbs_stb_o), 64'(3'b100));
            check_eq($sformatf("nw_quiet_%0d", k), 64'({wbm_err_o, timeout_o}), 64'(0));
            nxt();
        end
        m_idle();
        @(negedge clk);
        check_eq("nw_abort_stb", 64'(wbs_stb_o), 64'(0));
        check_eq("nw_err_adr", 64'(err_adr_o), 64'(last_err_adr));
        nxt();
`endif

        // ---------------- ack in the expiry cycle ----------------
        m_req(32'h1000, 3'b000);
        nxt();
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            check_eq($sformatf("ax_stb_%0d", k), 64'(wbs_stb_o), 64'(3'b010));
            nxt();
        end
        s_ack(1, 32'hA5A5_5A5A);
        push_exp(R_ACK, 32'hA5A5_5A5A);
        @(negedge clk);
        check_eq("ax_no_tout", 64'({wbm_err_o, timeout_o}), 64'(0));
        nxt();
        s_clear();
        m_idle();
        @(negedge clk);
        check_eq("ax_after", 64'({wbm_err_o, timeout_o}), 64'(0));
        nxt();

        // ---------------- abort in the expiry cycle ----------------
        m_req(32'h2000, 3'b000);
        nxt();
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            check_eq($sformatf("ab_stb_%0d", k), 64'(wbs_stb_o), 64'(3'b100));
            nxt();
        end
        m_idle();
        @(negedge clk);
        check_eq("ab_stb_drop", 64'(wbs_stb_o), 64'(0));
        nxt();
        @(negedge clk);
        check_eq("ab_no_tout", 64'({wbm_err_o, timeout_o, decode_err_o}), 64'(0));
        check_eq("ab_err_adr", 64'(err_adr_o), 64'(last_err_adr));
        nxt();

        // ---------------- 4-beat incrementing burst at 0x0000 ----------------
        m_req(32'h0000, 3'b010);
        nxt();
        for (int b = 0; b < 4; b++) begin
            wbm_adr_i = 32'(b * 4);
            wbm_cti_i = (b < 3) ? 3'b010 : 3'b111;
            s_clear();
            s_ack(0, 32'h0000_1000 + 32'(b));
            push_exp(R_ACK, 32'h0000_1000 + 32'(b));
            @(negedge clk);
            check_eq($sformatf("bu_stb_%0d", b), 64'(wbs_stb_o), 64'(3'b001));
            nxt();
        end
        s_clear();
        @(negedge clk);
        check_eq("bu_idle", 64'(wbs_stb_o), 64'(0));
        #1;
        m_idle();
        nxt();

        // ---------------- async reset mid-transfer ----------------
        m_req(32'h1000, 3'b000);
        nxt();
        @(negedge clk);
        check_eq("ar_stb_pre", 64'(wbs_stb_o), 64'(3'b010));
        #1;
        s_ack(1, 32'h7777_7777);
        #1;
        rst = 1'b1;
        #1;
        check_eq("ar_stb", 64'(wbs_stb_o), 64'(0));
        check_eq("ar_cyc", 64'(wbs_cyc_o), 64'(0));
        check_eq("ar_resp", 64'({wbm_rty_o, wbm_err_o, wbm_ack_o}), 64'(0));
        check_eq("ar_dat", 64'(wbm_dat_o), 64'(0));
        check_eq("ar_err_adr", 64'(err_adr_o), 64'(0));
        s_clear();
        m_idle();
        nxt();
        rst = 1'b0;
        nxt();
        m_req(32'h1000, 3'b000);
        nxt();
        s_ack(1, 32'h1234_5678);
        push_exp(R_ACK, 32'h1234_5678);
        @(negedge clk);
        check_eq("ar_fresh_stb", 64'(wbs_stb_o), 64'(3'b010));
        nxt();
        s_clear();
        m_idle();
        @(negedge clk);
        check_eq("ar_fresh_done", 64'(wbs_stb_o), 64'(0));
        nxt();

        check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
